cmos_pwr_seq: RTL and testbench

//  Power-up/reset sequencer for one OV5640 sensor and its cmos_rpll. Runs on the free-running

---
 rtl/cmos_pkg.sv | 22 ++
 rtl/cmos_pwr_seq_if.sv | 24 ++
 rtl/cmos_lock_sync.sv | 44 ++++
 rtl/cmos_pwr_seq.sv | 123 ++++++++++++
 tb/tb_cmos_pwr_seq.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cmos_pkg.sv
// Shared types and 50 MHz default timing for the OV5640 power-up sequencer.
package cmos_pkg;

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_LOCK,
        S_PWDN,
        S_REL,
        S_SCCB,
        S_CFG,
        S_READY
    } state_t;

    localparam int unsigned CNT_W_DEF        = 20;
    localparam int unsigned PLL_RST_CYC_DEF  = 32;
    localparam int unsigned LOCK_STB_CYC_DEF = 1024;
    localparam int unsigned LOCK_TO_CYC_DEF  = 500_000;
    localparam int unsigned T_PWDN_CYC_DEF   = 250_000;
    localparam int unsigned T_RST_CYC_DEF    = 50_000;
    localparam int unsigned T_SCCB_CYC_DEF   = 1_000_000;

endpackage

// File: rtl/cmos_pwr_seq_if.sv
// Sequencer-facing bundle: PLL lock, sensor control pins and SCCB config handshake.
interface cmos_pwr_seq_if;

    logic pll_lock;
    logic restart;
    logic init_done;
    logic pll_rst;
    logic cmos_pwdn;
    logic cmos_rst_n;
    logic cfg_start;
    logic cam_ready;
    logic lock_err;

    modport master (
        output pll_lock, restart, init_done,
        input  pll_rst, cmos_pwdn, cmos_rst_n, cfg_start, cam_ready, lock_err
    );

    modport slave (
        input  pll_lock, restart, init_done,
        output pll_rst, cmos_pwdn, cmos_rst_n, cfg_start, cam_ready, lock_err
    );

endinterface

// File: rtl/cmos_lock_sync.sv
// Brings the asynchronous PLL lock into clk and flags a run of consecutive synced highs.
module cmos_lock_sync
    import cmos_pkg::*;
#(
    parameter int unsigned LOCK_STB_CYC = LOCK_STB_CYC_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_lock,
    input  logic clear,
    output logic lock_s,
    output logic lock_stable
);

    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(LOCK_STB_CYC - 1);

    logic             meta;
    logic [CNT_W-1:0] run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            meta   <= pll_lock;
            lock_s <= meta;
        end
    end

    // run counts synced-high cycles already seen; the current high cycle completes the window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= '0;
        end else if (clear || !lock_s) begin
            run <= '0;
        end else if (run != RUN_LAST) begin
            run <= run + 1'b1;
        end
    end

    assign lock_stable = lock_s && (run == RUN_LAST);

endmodule

// File: rtl/cmos_pwr_seq.sv
// OV5640 power-up sequencer: PLL reset and lock qualification, PWDN/RESETB timing, SCCB kick-off.
module cmos_pwr_seq
    import cmos_pkg::*;
#(
    parameter int unsigned PLL_RST_CYC  = PLL_RST_CYC_DEF,
    parameter int unsigned LOCK_STB_CYC = LOCK_STB_CYC_DEF,
    parameter int unsigned LOCK_TO_CYC  = LOCK_TO_CYC_DEF,
    parameter int unsigned T_PWDN_CYC   = T_PWDN_CYC_DEF,
    parameter int unsigned T_RST_CYC    = T_RST_CYC_DEF,
    parameter int unsigned T_SCCB_CYC   = T_SCCB_CYC_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    cmos_pwr_seq_if.slave cam
);

    localparam logic [CNT_W-1:0] PLL_LAST  = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TO_CYC - 1);
    localparam logic [CNT_W-1:0] PWDN_LAST = CNT_W'(T_PWDN_CYC - 1);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(T_RST_CYC - 1);
    localparam logic [CNT_W-1:0] SCCB_LAST = CNT_W'(T_SCCB_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lock_s;
    logic             lock_stable;
    logic             lock_clr;
    logic             lock_lost;
    logic             pll_rst_q, pwdn_q, crst_n_q, cfg_q, ready_q, err_q;

    assign lock_clr  = (state != S_LOCK);
    assign lock_lost = !lock_s && (state inside {S_PWDN, S_REL, S_SCCB, S_CFG, S_READY});

    cmos_lock_sync #(
        .LOCK_STB_CYC (LOCK_STB_CYC),
        .CNT_W        (CNT_W)
    ) u_lock_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_lock    (cam.pll_lock),
        .clear       (lock_clr),
        .lock_s      (lock_s),
        .lock_stable (lock_stable)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_PLL_RST;
            cnt       <= '0;
            pll_rst_q <= 1'b1;
            pwdn_q    <= 1'b1;
            crst_n_q  <= 1'b0;
            cfg_q     <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cfg_q <= 1'b0;
            cnt   <= (cnt == '1) ? cnt : cnt + 1'b1;
            if (cam.restart || lock_lost) begin
                state     <= S_PLL_RST;
                cnt       <= '0;
                pll_rst_q <= 1'b1;
                pwdn_q    <= 1'b1;
                crst_n_q  <= 1'b0;
                ready_q   <= 1'b0;
                // restart clears the sticky error even when lock drops in the same cycle
                err_q     <= !cam.restart;
            end else begin
                case (state)
                    S_PLL_RST: if (cnt == PLL_LAST) begin
                        state     <= S_LOCK;
                        cnt       <= '0;
                        pll_rst_q <= 1'b0;
                    end
                    S_LOCK: if (lock_stable) begin
                        state <= S_PWDN;
                        cnt   <= '0;
                    end else if (cnt == TO_LAST) begin
                        state     <= S_PLL_RST;
                        cnt       <= '0;
                        pll_rst_q <= 1'b1;
                        err_q     <= 1'b1;
                    end
                    S_PWDN: if (cnt == PWDN_LAST) begin
                        state  <= S_REL;
                        cnt    <= '0;
                        pwdn_q <= 1'b0;
                    end
                    S_REL: if (cnt == REL_LAST) begin
                        state    <= S_SCCB;
                        cnt      <= '0;
                        crst_n_q <= 1'b1;
                    end
                    S_SCCB: if (cnt == SCCB_LAST) begin
                        state <= S_CFG;
                        cnt   <= '0;
                        cfg_q <= 1'b1;
                    end
                    S_CFG: if (cam.init_done) begin
                        state   <= S_READY;
                        cnt     <= '0;
                        ready_q <= 1'b1;
                    end
                    S_READY: ;
                    default: begin
                        state     <= S_PLL_RST;
                        cnt       <= '0;
                        pll_rst_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign cam.pll_rst    = pll_rst_q;
    assign cam.cmos_pwdn  = pwdn_q;
    assign cam.cmos_rst_n = crst_n_q;
    assign cam.cfg_start  = cfg_q;
    assign cam.cam_ready  = ready_q;
    assign cam.lock_err   = err_q;

endmodule

// File: tb/tb_cmos_pwr_seq.sv
// Cycle-exact trace bench for cmos_pwr_seq with small timing parameters.
module tb_cmos_pwr_seq;

    // expected output vector order: {pll_rst, cmos_pwdn, cmos_rst_n, cfg_start, cam_ready, lock_err}
    typedef struct {
        int         tst;
        int         cyc;
        logic       lock;
        logic       rs;
        logic       init;
        logic [5:0] exp;
    } vec_t;

    typedef struct {
        int         tst;
        int         cyc;
        logic [5:0] exp;
    } sb_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_cfg  = 0;
    vec_t tbl[$];
    sb_t  sbq[$];

    cmos_pwr_seq_if cam_bus ();

    cmos_pwr_seq #(
        .PLL_RST_CYC  (4),
        .LOCK_STB_CYC (8),
        .LOCK_TO_CYC  (40),
        .T_PWDN_CYC   (10),
        .T_RST_CYC    (5),
        .T_SCCB_CYC   (20),
        .CNT_W        (20)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cam   (cam_bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [5:0] outs_now();
        return {cam_bus.pll_rst, cam_bus.cmos_pwdn, cam_bus.cmos_rst_n,
                cam_bus.cfg_start, cam_bus.cam_ready, cam_bus.lock_err};
    endfunction

    task automatic check_vec(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic add(input int t, input int c, input logic l, input logic r,
                       input logic i, input logic [5:0] e);
        vec_t v;
        v = '{t, c, l, r, i, e};
        tbl.push_back(v);
    endtask

    // lock rises at cycle 5, cfg_start at 50, init_done driven at 52
    task automatic add_nominal(input int t);
        add(t,  0, 1'b0, 1'b0, 1'b0, 6'b110000);
        add(t,  4, 1'b0, 1'b0, 1'b0, 6'b010000);
        add(t,  5, 1'b1, 1'b0, 1'b0, 6'b010000);
        add(t, 25, 1'b1, 1'b0, 1'b0, 6'b000000);
        add(t, 30, 1'b1, 1'b0, 1'b0, 6'b001000);
        add(t, 50, 1'b1, 1'b0, 1'b0, 6'b001100);
        add(t, 51, 1'b1, 1'b0, 1'b0, 6'b001000);
        add(t, 52, 1'b1, 1'b0, 1'b1, 6'b001000);
        add(t, 53, 1'b1, 1'b0, 1'b1, 6'b001010);
    endtask

    task automatic fill_table();
        add_nominal(1);
        add(1, 60, 1'b1, 1'b0, 1'b1, 6'b001010);
        // lock glitch at cycle 10 restarts the filter
        add(2,  0, 1'b0, 1'b0, 1'b0, 6'b110000);
        add(2,  4, 1'b0, 1'b0, 1'b0, 6'b010000);
        add(2,  5, 1'b1, 1'b0, 1'b0, 6'b010000);
        add(2, 10, 1'b0, 1'b0, 1'b0, 6'b010000);
        add(2, 11, 1'b1, 1'b0, 1'b0, 6'b010000);
        add(2, 31, 1'b1, 1'b0, 1'b0, 6'b000000);
        add(2, 36, 1'b1, 1'b0, 1'b0, 6'b001000);
        add(2, 56, 1'b1, 1'b0, 1'b0, 6'b001100);
        add(2, 57, 1'b1, 1'b0, 1'b0, 6'b001000);
        add(2, 60, 1'b1, 1'b0, 1'b0, 6'b001000);
        // lock timeout, then recovery with lock_err held
        add(3,  0, 1'b0, 1'b0, 1'b0, 6'b110000);
        add(3,  4, 1'b0, 1'b0, 1'b0, 6'b010000);
        add(3, 44, 1'b0, 1'b0, 1'b0, 6'b110001);
        add(3, 48, 1'b0, 1'b0, 1'b0, 6'b010001);
        add(3, 50, 1'b1, 1'b0, 1'b0, 6'b010001);
        add(3, 70, 1'b1, 1'b0, 1'b0, 6'b000001);
        add(3, 75, 1'b1, 1'b0, 1'b0, 6'b001001);
        add(3, 95, 1'b1, 1'b0, 1'b0, 6'b001101);
        add(3, 96, 1'b1, 1'b0, 1'b0, 6'b001001);
        add(3, 97, 1'b1, 1'b0, 1'b1, 6'b001001);
        add(3, 98, 1'b1, 1'b0, 1'b1, 6'b001011);
        add(3, 102, 1'b1, 1'b0, 1'b1, 6'b001011);
        // lock loss in S_READY
        add_nominal(4);
        add(4, 58, 1'b0, 1'b0, 1'b1, 6'b001010);
        add(4, 61, 1'b0, 1'b0, 1'b1, 6'b110001);
        add(4, 65, 1'b0, 1'b0, 1'b1, 6'b010001);
        add(4, 70, 1'b0, 1'b0, 1'b1, 6'b010001);
        // restart in S_SCCB, then restart coinciding with lock loss
        add(5,  0, 1'b0, 1'b0, 1'b0, 6'b110000);
        add(5,  4, 1'b0, 1'b0, 1'b0, 6'b010000);
        add(5,  5, 1'b1, 1'b0, 1'b0, 6'b010000);
        add(5, 25, 1'b1, 1'b0, 1'b0, 6'b000000);
        add(5, 30, 1'b1, 1'b0, 1'b0, 6'b001000);
        add(5, 35, 1'b1, 1'b1, 1'b0, 6'b001000);
        add(5, 36, 1'b1, 1'b0, 1'b0, 6'b110000);
        add(5, 40, 1'b1, 1'b0, 1'b0, 6'b010000);
        add(5, 58, 1'b1, 1'b0, 1'b0, 6'b000000);
        add(5, 63, 1'b1, 1'b0, 1'b0, 6'b001000);
        add(5, 66, 1'b0, 1'b0, 1'b0, 6'b001000);
        add(5, 68, 1'b0, 1'b1, 1'b0, 6'b001000);
        add(5, 69, 1'b0, 1'b0, 1'b0, 6'b110000);
        add(5, 70, 1'b1, 1'b0, 1'b0, 6'b110000);
        add(5, 73, 1'b1, 1'b0, 1'b0, 6'b010000);
        add(5, 91, 1'b1, 1'b0, 1'b0, 6'b000000);
        add(5, 96, 1'b1, 1'b0, 1'b0, 6'b001000);
        add(5, 116, 1'b1, 1'b0, 1'b0, 6'b001100);
        add(5, 117, 1'b1, 1'b0, 1'b0, 6'b001000);
        add(5, 118, 1'b1, 1'b0, 1'b1, 6'b001000);
        add(5, 119, 1'b1, 1'b0, 1'b1, 6'b001010);
        add(5, 122, 1'b1, 1'b0, 1'b1, 6'b001010);
        // init_done high throughout
        add(6,  0, 1'b0, 1'b0, 1'b1, 6'b110000);
        add(6,  4, 1'b0, 1'b0, 1'b1, 6'b010000);
        add(6,  5, 1'b1, 1'b0, 1'b1, 6'b010000);
        add(6, 25, 1'b1, 1'b0, 1'b1, 6'b000000);
        add(6, 30, 1'b1, 1'b0, 1'b1, 6'b001000);
        add(6, 50, 1'b1, 1'b0, 1'b1, 6'b001100);
        add(6, 51, 1'b1, 1'b0, 1'b1, 6'b001010);
        add(6, 55, 1'b1, 1'b0, 1'b1, 6'b001010);
    endtask

    task automatic hw_reset();
        rst_n             = 1'b0;
        cam_bus.pll_lock  = 1'b0;
        cam_bus.restart   = 1'b0;
        cam_bus.init_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cfg = 0;
        rst_n = 1'b1;
    endtask

    // pops one expectation per falling edge and compares the whole output vector
    task automatic monitor();
        sb_t e;
        forever begin
            @(negedge clk);
            if (rst_n && cam_bus.cfg_start) n_cfg++;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.cyc != cyc) check_int("sb_align", cyc, e.cyc);
                check_vec($sformatf("t%0d_c%0d", e.tst, e.cyc), outs_now(), e.exp);
            end
        end
    endtask

    task automatic run_test(input int t);
        vec_t       rec[$];
        sb_t        s;
        logic [5:0] cur;
        int         last;
        int         k;
        foreach (tbl[i]) if (tbl[i].tst == t) rec.push_back(tbl[i]);
        last = rec[rec.size()-1].cyc;
        hw_reset();
        k   = 0;
        cur = '0;
        for (int c = 0; c <= last; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (k < rec.size() && rec[k].cyc == c) begin
                cam_bus.pll_lock  = rec[k].lock;
                cam_bus.restart   = rec[k].rs;
                cam_bus.init_done = rec[k].init;
                cur = rec[k].exp;
                k++;
            end
            s = '{t, c, cur};
            sbq.push_back(s);
        end
        @(negedge clk);
        #1;
        check_int($sformatf("t%0d_cfg_pulses", t), n_cfg, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        fill_table();
        fork
            monitor();
        join_none
        for (int t = 1; t <= 6; t++) run_test(t);

        // asynchronous reset while in S_REL
        hw_reset();
        cam_bus.pll_lock = 1'b1;
        while (cyc < 24) begin
            @(posedge clk);
            #1;
        end
        check_vec("rel_state", outs_now(), 6'b000000);
        #2 rst_n = 1'b0;
        #1;
        check_vec("async_rst", outs_now(), 6'b110000);
        #10 rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
